// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous D_MEM between the CPU and host ports.
// Optional grant/conflict statistics are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // CPU load/store port
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    // host/debug port
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_host_ack,
`ifdef DMEM_ARB_STATS_EN
    input  logic              i_stats_clr,
    output logic [CNT_W-1:0]  o_cpu_grant_cnt,
    output logic [CNT_W-1:0]  o_host_grant_cnt,
    output logic [CNT_W-1:0]  o_conflict_cnt,
`endif
    // memory side
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic SEL_CPU  = 1'b0;
    localparam logic SEL_HOST = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   r_last;
    logic   w_winner;
    logic   w_issue;

    // On a tie the requester that did not win last time gets the slot.
    assign w_winner = (i_cpu_req && i_host_req) ? ~r_last : i_host_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_owner <= SEL_CPU;
            r_last  <= SEL_HOST;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_owner <= w_winner;
                r_last  <= w_winner;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        o_mem_en     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_cpu_ack    = 1'b0;
        o_host_ack   = 1'b0;
        o_cpu_rdata  = '0;
        o_host_rdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_cpu_req || i_host_req) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_BUSY;
                    o_mem_en    = 1'b1;
                    if (w_winner == SEL_HOST) begin
                        o_mem_we    = i_host_we;
                        o_mem_addr  = i_host_addr;
                        o_mem_wdata = i_host_wdata;
                    end else begin
                        o_mem_we    = i_cpu_we;
                        o_mem_addr  = i_cpu_addr;
                        o_mem_wdata = i_cpu_wdata;
                    end
                end
            end
            ST_BUSY: begin
                w_state_nxt = ST_IDLE;
                if (r_owner == SEL_HOST) begin
                    o_host_ack   = 1'b1;
                    o_host_rdata = i_mem_rdata;
                end else begin
                    o_cpu_ack    = 1'b1;
                    o_cpu_rdata  = i_mem_rdata;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Reset must silence the combinational request path too, not just the state.
        if (i_rst) begin
            w_issue      = 1'b0;
            o_mem_en     = 1'b0;
            o_mem_we     = 1'b0;
            o_mem_addr   = '0;
            o_mem_wdata  = '0;
            o_cpu_ack    = 1'b0;
            o_host_ack   = 1'b0;
            o_cpu_rdata  = '0;
            o_host_rdata = '0;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [CNT_W-1:0] r_cpu_cnt;
    logic [CNT_W-1:0] r_host_cnt;
    logic [CNT_W-1:0] r_conf_cnt;
    logic             w_conflict;

    assign w_conflict = (r_state == ST_IDLE) && i_cpu_req && i_host_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cpu_cnt  <= '0;
            r_host_cnt <= '0;
            r_conf_cnt <= '0;
        end else if (i_stats_clr) begin
            r_cpu_cnt  <= '0;
            r_host_cnt <= '0;
            r_conf_cnt <= '0;
        end else begin
            if (w_issue && (w_winner == SEL_CPU) && (r_cpu_cnt != '1))
                r_cpu_cnt <= r_cpu_cnt + CNT_W'(1);
            if (w_issue && (w_winner == SEL_HOST) && (r_host_cnt != '1))
                r_host_cnt <= r_host_cnt + CNT_W'(1);
            if (w_conflict && (r_conf_cnt != '1))
                r_conf_cnt <= r_conf_cnt + CNT_W'(1);
        end
    end

    assign o_cpu_grant_cnt  = r_cpu_cnt;
    assign o_host_grant_cnt = r_host_cnt;
    assign o_conflict_cnt   = r_conf_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset/contention sequences and a randomized
// run checked against a transaction-level model with its own copy of memory.
module tb_dmem_arbiter;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, host_req, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic          cpu_ack, host_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
    logic          stats_clr = 1'b0;
    logic [CW-1:0] cpu_cnt, host_cnt, conf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_rdata(host_rdata), .o_host_ack(host_ack),
`ifdef DMEM_ARB_STATS_EN
        .i_stats_clr(stats_clr), .o_cpu_grant_cnt(cpu_cnt), .o_host_grant_cnt(host_cnt),
        .o_conflict_cnt(conf_cnt),
`endif
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Single-port synchronous memory behind the arbiter.
    logic [DW-1:0] hmem [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) hmem[mem_addr] <= mem_wdata;
            else        mem_rdata <= hmem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
        chk({tag, "_host_ack"}, 32'(host_ack), 0);
        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
        chk({tag, "_host_rdata"}, 32'(host_rdata), 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          creq, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          hreq, hwe;
        logic [AW-1:0] haddr;
        logic [DW-1:0] hwd;
        logic          en, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          cack, hack, rdchk;
        logic [DW-1:0] rd;
    } vec_t;

    function automatic vec_t mk(logic creq, logic cwe, logic [AW-1:0] caddr, logic [DW-1:0] cwd,
                                logic hreq, logic hwe, logic [AW-1:0] haddr, logic [DW-1:0] hwd,
                                logic en, logic we, logic [AW-1:0] addr, logic [DW-1:0] wd,
                                logic cack, logic hack, logic rdchk, logic [DW-1:0] rd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
        v.en = en; v.we = we; v.addr = addr; v.wd = wd;
        v.cack = cack; v.hack = hack; v.rdchk = rdchk; v.rd = rd;
        return v;
    endfunction

    // Random-phase requester and model state
    logic          c_act, c_done, h_act, h_done;
    logic          fl_v, fl_host, fl_we, last_host, win_host;
    logic [DW-1:0] fl_rd;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          e_en, e_we, e_cack, e_hack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;

    initial begin
        vec_t tbl[17];
        int   cpu_acks, host_acks;

        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1; host_we = 1; host_addr = 8'h05; host_wdata = 16'h5555;

        //            cpu req/we/addr/wd     host req/we/addr/wd        exp en/we/addr/wd      cack hack rdchk rd
        tbl[0]  = mk(0, 0, 0, 16'h0000,     1, 1, 0, 16'h1234,         1, 1, 0, 16'h1234,     0, 0, 0, 16'h0000);
        tbl[1]  = mk(0, 0, 0, 16'h0000,     1, 1, 0, 16'h1234,         0, 0, 0, 16'h0000,     0, 1, 0, 16'h0000);
        tbl[2]  = mk(0, 0, 0, 16'h0000,     1, 1, 1, 16'hABCD,         1, 1, 1, 16'hABCD,     0, 0, 0, 16'h0000);
        tbl[3]  = mk(0, 0, 0, 16'h0000,     1, 1, 1, 16'hABCD,         0, 0, 0, 16'h0000,     0, 1, 0, 16'h0000);
        tbl[4]  = mk(0, 0, 0, 16'h0000,     1, 0, 0, 16'h0000,         1, 0, 0, 16'h0000,     0, 0, 0, 16'h0000);
        tbl[5]  = mk(0, 0, 0, 16'h0000,     1, 0, 0, 16'h0000,         0, 0, 0, 16'h0000,     0, 1, 1, 16'h1234);
        tbl[6]  = mk(0, 0, 0, 16'h0000,     1, 0, 1, 16'h0000,         1, 0, 1, 16'h0000,     0, 0, 0, 16'h0000);
        tbl[7]  = mk(0, 0, 0, 16'h0000,     1, 0, 1, 16'h0000,         0, 0, 0, 16'h0000,     0, 1, 1, 16'hABCD);
        tbl[8]  = mk(1, 0, 2, 16'h0000,     1, 0, 3, 16'h0000,         1, 0, 2, 16'h0000,     0, 0, 0, 16'h0000);
        tbl[9]  = mk(1, 0, 2, 16'h0000,     1, 0, 3, 16'h0000,         0, 0, 0, 16'h0000,     1, 0, 1, 16'h0000);
        tbl[10] = mk(0, 0, 0, 16'h0000,     1, 0, 3, 16'h0000,         1, 0, 3, 16'h0000,     0, 0, 0, 16'h0000);
        tbl[11] = mk(0, 0, 0, 16'h0000,     1, 0, 3, 16'h0000,         0, 0, 0, 16'h0000,     0, 1, 1, 16'h0000);
        tbl[12] = mk(1, 1, 2, 16'h00FF,     0, 0, 0, 16'h0000,         1, 1, 2, 16'h00FF,     0, 0, 0, 16'h0000);
        tbl[13] = mk(1, 1, 2, 16'h00FF,     0, 0, 0, 16'h0000,         0, 0, 0, 16'h0000,     1, 0, 0, 16'h0000);
        tbl[14] = mk(0, 0, 0, 16'h0000,     1, 0, 2, 16'h0000,         1, 0, 2, 16'h0000,     0, 0, 0, 16'h0000);
        tbl[15] = mk(0, 0, 0, 16'h0000,     1, 0, 2, 16'h0000,         0, 0, 0, 16'h0000,     0, 1, 1, 16'h00FF);
        tbl[16] = mk(0, 0, 0, 16'h0000,     0, 0, 0, 16'h0000,         0, 0, 0, 16'h0000,     0, 0, 0, 16'h0000);

        // Reset holds everything quiet even with a request pending.
        @(negedge clk);
        chk_quiet("reset");
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
            host_req = tbl[i].hreq; host_we = tbl[i].hwe; host_addr = tbl[i].haddr; host_wdata = tbl[i].hwd;
            @(negedge clk);
            chk($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
            chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].wd));
            chk($sformatf("vec%0d_cpu_ack", i), 32'(cpu_ack), 32'(tbl[i].cack));
            chk($sformatf("vec%0d_host_ack", i), 32'(host_ack), 32'(tbl[i].hack));
            if (tbl[i].rdchk)
                chk($sformatf("vec%0d_rdata", i), 32'(tbl[i].cack ? cpu_rdata : host_rdata), 32'(tbl[i].rd));
            next_cycle();
        end

        // Reset during BUSY of a host read: no ack, outputs silent at once.
        host_req = 1; host_we = 0; host_addr = 8'd0; host_wdata = '0;
        @(negedge clk);
        chk("rstmid_issue_en", 32'(mem_en), 1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("rstmid_busy");
        next_cycle();
        rst = 1'b0;
        host_req = 0;
        @(negedge clk);
        chk("rstmid_after_hack", 32'(host_ack), 0);
        chk("rstmid_after_en", 32'(mem_en), 0);
        next_cycle();

        // First tie after reset goes to the CPU.
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'd2;
        host_req = 1; host_we = 0; host_addr = 8'd3;
        @(negedge clk);
        chk("tie_n_en", 32'(mem_en), 1);
        chk("tie_n_addr", 32'(mem_addr), 2);
        chk("tie_n_cack", 32'(cpu_ack), 0);
        next_cycle();
        @(negedge clk);
        chk("tie_n1_cack", 32'(cpu_ack), 1);
        chk("tie_n1_crd", 32'(cpu_rdata), 32'h00FF);
        chk("tie_n1_hack", 32'(host_ack), 0);
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        chk("tie_n2_en", 32'(mem_en), 1);
        chk("tie_n2_addr", 32'(mem_addr), 3);
        chk("tie_n2_hack", 32'(host_ack), 0);
        next_cycle();
        @(negedge clk);
        chk("tie_n3_hack", 32'(host_ack), 1);
        chk("tie_n3_hrd", 32'(host_rdata), 0);
        chk("tie_n3_cack", 32'(cpu_ack), 0);
        next_cycle();
        host_req = 0;
`ifdef DMEM_ARB_STATS_EN
        @(negedge clk);
        chk("stats_tie_cpu", 32'(cpu_cnt), 1);
        chk("stats_tie_host", 32'(host_cnt), 1);
        chk("stats_tie_conf", 32'(conf_cnt), 1);
        stats_clr = 1'b1;
        next_cycle();
        stats_clr = 1'b0;
        @(negedge clk);
        chk("stats_clr1_cpu", 32'(cpu_cnt), 0);
        chk("stats_clr1_host", 32'(host_cnt), 0);
        chk("stats_clr1_conf", 32'(conf_cnt), 0);
        next_cycle();
`endif

        // Sustained contention: grants alternate starting with the CPU.
        cpu_acks = 0; host_acks = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'd0;
        host_req = 1; host_we = 0; host_addr = 8'd1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk($sformatf("cont%0d_en", k), 32'(mem_en), 1);
                chk($sformatf("cont%0d_addr", k), 32'(mem_addr), ((k / 2) % 2 == 0) ? 0 : 1);
            end else begin
                chk($sformatf("cont%0d_cack", k), 32'(cpu_ack), ((k / 2) % 2 == 0) ? 1 : 0);
                chk($sformatf("cont%0d_hack", k), 32'(host_ack), ((k / 2) % 2 == 0) ? 0 : 1);
            end
            if (cpu_ack) cpu_acks++;
            if (host_ack) host_acks++;
            next_cycle();
        end
        cpu_req = 0; host_req = 0;
        chk("cont_cpu_acks", 32'(cpu_acks), 4);
        chk("cont_host_acks", 32'(host_acks), 4);
`ifdef DMEM_ARB_STATS_EN
        @(negedge clk);
        chk("stats_cont_cpu", 32'(cpu_cnt), 4);
        chk("stats_cont_host", 32'(host_cnt), 4);
        chk("stats_cont_conf", 32'(conf_cnt), 8);
        stats_clr = 1'b1;
        next_cycle();
        stats_clr = 1'b0;
        @(negedge clk);
        chk("stats_clr2_cpu", 32'(cpu_cnt), 0);
        chk("stats_clr2_host", 32'(host_cnt), 0);
        chk("stats_clr2_conf", 32'(conf_cnt), 0);
`endif
        next_cycle();

        // Randomized run against the transaction-level model, starting from a fresh reset.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int a = 0; a < (1 << AW); a++) ref_mem[a] = hmem[a];
        c_act = 0; c_done = 0; h_act = 0; h_done = 0;
        fl_v = 0; fl_host = 0; fl_we = 0; fl_rd = '0; last_host = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!c_act || c_done) begin
                c_done = 0; c_act = 1'($urandom_range(0, 1));
                cpu_we = 1'($urandom); cpu_addr = AW'($urandom_range(0, 7)); cpu_wdata = DW'($urandom);
            end
            if (!h_act || h_done) begin
                h_done = 0; h_act = 1'($urandom_range(0, 1));
                host_we = 1'($urandom); host_addr = AW'($urandom_range(0, 7)); host_wdata = DW'($urandom);
            end
            cpu_req = c_act; host_req = h_act;
            @(negedge clk);
            e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_cack = 0; e_hack = 0;
            if (fl_v) begin
                if (fl_host) begin e_hack = 1; h_done = 1; end
                else         begin e_cack = 1; c_done = 1; end
                if (!fl_we)
                    chk($sformatf("rnd%0d_rdata", cyc), 32'(fl_host ? host_rdata : cpu_rdata), 32'(fl_rd));
                fl_v = 0;
            end else if (cpu_req || host_req) begin
                win_host = host_req && (!cpu_req || !last_host);
                e_en   = 1;
                e_we   = win_host ? host_we : cpu_we;
                e_addr = win_host ? host_addr : cpu_addr;
                e_wd   = win_host ? host_wdata : cpu_wdata;
                if (e_we) ref_mem[e_addr] = e_wd;
                else      fl_rd = ref_mem[e_addr];
                fl_v = 1; fl_host = win_host; fl_we = e_we; last_host = win_host;
            end
            chk($sformatf("rnd%0d_en", cyc), 32'(mem_en), 32'(e_en));
            chk($sformatf("rnd%0d_we", cyc), 32'(mem_we), 32'(e_we));
            chk($sformatf("rnd%0d_addr", cyc), 32'(mem_addr), 32'(e_addr));
            chk($sformatf("rnd%0d_wdata", cyc), 32'(mem_wdata), 32'(e_wd));
            chk($sformatf("rnd%0d_cack", cyc), 32'(cpu_ack), 32'(e_cack));
            chk($sformatf("rnd%0d_hack", cyc), 32'(host_ack), 32'(e_hack));
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
